uart_rx_sampler: RTL and testbench

UART_RX_SAMPLER -- requirements
Module: uart_rx_sampler

---
 rtl/uart_rx_sampler.sv | 141 ++++++++++++++
 tb/tb_uart_rx_sampler.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_sampler.sv
// UART receiver: 8N1, LSB first, with a 2-flop input synchronizer and mid-bit sampling.
// Produces one-cycle donerx/ferr pulses, and holds the last good byte on rx_data.
module uart_rx_sampler #(
  parameter int CLK_FREQ = 1000000,
  parameter int BAUD     = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       donerx,
  output logic       ferr,
  output logic       busy
);

  localparam int BIT_CLKS = CLK_FREQ / BAUD;
  localparam int HALF     = BIT_CLKS / 2;
  localparam int CNT_W    = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CLKS - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  logic             rx_meta_q, rx_sync_q, rx_prev_q;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             donerx_q, donerx_d;
  logic             ferr_q, ferr_d;
  logic             busy_q, busy_d;
  logic             fall;

  // rx_prev_q lags the synchronized line by one cycle, so that a falling edge can be detected.
  assign fall = rx_prev_q & ~rx_sync_q;

  always_comb begin
    // NOTE: every _d gets a default first, so no path through the case leaves one unassigned (no latches).
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    rx_data_d = rx_data_q;
    donerx_d  = 1'b0;
    ferr_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (fall) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = rx_sync_q ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d     = '0;
          shift_d   = {rx_sync_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 1'b1;
          if (bit_idx_q == 3'd7) state_d = STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rx_sync_q) begin
            rx_data_d = shift_q;
            donerx_d  = 1'b1;
            state_d   = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = BREAK;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      BREAK: begin
        // A line held low is not a new start bit; wait for it to return high.
        if (rx_sync_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // NOTE: every register here is reset, including the data registers, so that nothing powers up as X.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      rx_data_q <= '0;
      donerx_q  <= 1'b0;
      ferr_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments, so every flop samples its pre-edge inputs.
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      rx_data_q <= rx_data_d;
      donerx_q  <= donerx_d;
      ferr_q    <= ferr_d;
      busy_q    <= busy_d;
    end
  end

  assign rx_data = rx_data_q;
  assign donerx  = donerx_q;
  assign ferr    = ferr_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Directed bench for uart_rx_sampler: a table of frames, then hand-written sequences for
// back-to-back frames, a glitch, reset mid-frame, and start-to-donerx latency.
module tb_uart_rx_sampler;

  localparam int CLK_FREQ = 1000000;
  localparam int BAUD     = 9600;
  localparam int BIT_CLKS = CLK_FREQ / BAUD;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx  = 1'b1;
  logic [7:0] rx_data;
  logic       donerx, ferr, busy;

  uart_rx_sampler #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .clk    (clk),
    .rst    (rst),
    .rx     (rx),
    .rx_data(rx_data),
    .donerx (donerx),
    .ferr   (ferr),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int done_cnt = 0;
  int ferr_cnt = 0;
  int both_cnt = 0;
  logic [7:0] got[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (donerx) begin
      done_cnt = done_cnt + 1;
      got.push_back(rx_data);
    end
    if (ferr) ferr_cnt = ferr_cnt + 1;
    if (donerx && ferr) both_cnt = both_cnt + 1;
  end

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         exp_done;
    int         exp_ferr;
    logic [7:0] exp_rx_data;
  } vec_t;

  vec_t vecs[8];
  logic [7:0] b2b[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    tick(BIT_CLKS);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop_bit);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop_bit);
  endtask

  task automatic clear_mon();
    done_cnt = 0;
    ferr_cnt = 0;
    got.delete();
  endtask

  int lat;
  int c0;
  int sz;

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 1, 0, 8'hA5};
    vecs[1] = '{8'h3C, 1'b0, 0, 1, 8'hA5};
    vecs[2] = '{8'h81, 1'b1, 1, 0, 8'h81};
    vecs[3] = '{8'h00, 1'b1, 1, 0, 8'h00};
    vecs[4] = '{8'hFF, 1'b1, 1, 0, 8'hFF};
    vecs[5] = '{8'h01, 1'b1, 1, 0, 8'h01};
    vecs[6] = '{8'h80, 1'b0, 0, 1, 8'h01};
    vecs[7] = '{8'h5A, 1'b1, 1, 0, 8'h5A};
    for (int i = 0; i < 10; i++) b2b[i] = 8'($urandom_range(0, 255));

    // Reset state.
    rst = 1'b0;
    rx  = 1'b1;
    tick(5);
    check("reset_rx_data", rx_data, 8'h00);
    check("reset_donerx", donerx, 1'b0);
    check("reset_ferr", ferr, 1'b0);
    check("reset_busy", busy, 1'b0);
    rst = 1'b1;
    tick(5);

    // Table of single frames, including framing errors followed by a held-low line.
    for (int i = 0; i < 8; i++) begin
      clear_mon();
      send_byte(vecs[i].data, vecs[i].stop);
      if (!vecs[i].stop) begin
        tick(300);
        check($sformatf("vec%0d_break_busy", i), busy, 1'b1);
        rx = 1'b1;
        tick(5);
      end
      tick(20);
      check($sformatf("vec%0d_done_cnt", i), done_cnt, vecs[i].exp_done);
      check($sformatf("vec%0d_ferr_cnt", i), ferr_cnt, vecs[i].exp_ferr);
      check($sformatf("vec%0d_rx_data", i), rx_data, vecs[i].exp_rx_data);
      check($sformatf("vec%0d_idle_busy", i), busy, 1'b0);
    end

    // Back-to-back frames with a one-bit stop.
    clear_mon();
    for (int i = 0; i < 10; i++) send_byte(b2b[i], 1'b1);
    tick(20);
    sz = got.size();
    check("b2b_count", sz, 10);
    check("b2b_ferr", ferr_cnt, 0);
    for (int i = 0; i < 10; i++)
      check($sformatf("b2b_byte%0d", i), (i < sz) ? {24'h0, got[i]} : 32'hxxxxxxxx, b2b[i]);

    // Glitch: 30 cycles low is rejected at the half-bit sample.
    clear_mon();
    rx = 1'b0;
    tick(10);
    check("glitch_busy_high", busy, 1'b1);
    tick(20);
    rx = 1'b1;
    tick(30);
    check("glitch_busy_low", busy, 1'b0);
    check("glitch_done", done_cnt, 0);
    check("glitch_ferr", ferr_cnt, 0);

    // Reset during bit 4 of 0xFF, then a clean 0x12.
    clear_mon();
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    rx = 1'b1;
    tick(50);
    rst = 1'b0;
    tick(1);
    check("midrst_busy", busy, 1'b0);
    check("midrst_rx_data", rx_data, 8'h00);
    tick(19);
    rst = 1'b1;
    tick(300);
    check("midrst_done", done_cnt, 0);
    check("midrst_ferr", ferr_cnt, 0);
    check("midrst_rx_data_hold", rx_data, 8'h00);
    check("midrst_idle", busy, 1'b0);
    send_byte(8'h12, 1'b1);
    tick(20);
    check("after_rst_done", done_cnt, 1);
    check("after_rst_rx_data", rx_data, 8'h12);

    // Start-edge to donerx latency for 0x00.
    clear_mon();
    tick(5);
    lat = -1;
    c0  = cyc;
    fork
      send_byte(8'h00, 1'b1);
      begin
        for (int k = 0; k < 1200; k++) begin
          @(negedge clk);
          if (donerx) begin
            lat = cyc - c0;
            break;
          end
        end
      end
    join
    tick(5);
    if (lat < 988 || lat > 992)
      $display("FAIL latency: got %0d cycles expected 988..992", lat);
    check("latency_in_range", (lat >= 988 && lat <= 992), 1'b1);
    check("latency_rx_data", rx_data, 8'h00);
    check("latency_done", done_cnt, 1);

    check("never_done_and_ferr", both_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
